// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back entry layout.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for pending register writes; exposes its storage, the read
// pointer and a per-slot valid mask so the owner can search pending entries.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = REG_ADDR_W + REG_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [W-1:0]                din,
  input  logic                        pop,
  output logic [W-1:0]                head,
  output logic [DEPTH-1:0][W-1:0]     entries,
  output logic [DEPTH-1:0]            valid,
  output logic [$clog2(DEPTH)-1:0]    rd_ptr,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Storage carries no reset; occupancy is defined solely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr;
      valid[i] = (CW'(off) < count);
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Register-file write port driver: arbitrates ALU/load results into an in-order
// queue, retires one write per cycle, and forwards the youngest pending value.
// Optional macro WB_BYPASS_EN loads results straight into the output stage when the queue is empty.
module regfile_writeback_queue
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic                        mem_acc;
  logic                        alu_acc;
  logic [ADDR_W-1:0]           in_rd;
  logic [DATA_W-1:0]           in_data;
  logic                        in_ok;
  logic                        push;
  logic                        bypass;
  logic                        pop;
  logic [EW-1:0]               head;
  logic [DEPTH-1:0][EW-1:0]    q_ent;
  logic [DEPTH-1:0]            q_valid;
  logic [PW-1:0]               q_rptr;

  // Ready never looks at the pop so there is no combinational path from the output stage.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_acc   = mem_valid && mem_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign in_rd     = mem_acc ? mem_rd   : alu_rd;
  assign in_data   = mem_acc ? mem_data : alu_data;
  assign in_ok     = (mem_acc || alu_acc) && (in_rd != ADDR_W'(ZERO_REG));
  assign pop       = !empty;

`ifdef WB_BYPASS_EN
  assign bypass = in_ok && empty;
  assign push   = in_ok && !empty;
`else
  assign bypass = 1'b0;
  assign push   = in_ok;
`endif

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     ({in_rd, in_data}),
    .pop     (pop),
    .head    (head),
    .entries (q_ent),
    .valid   (q_valid),
    .rd_ptr  (q_rptr),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (pop) begin
      RegWrite  <= 1'b1;
      writeReg  <= head[EW-1:DATA_W];
      writeData <= head[DATA_W-1:0];
    end else if (bypass) begin
      RegWrite  <= 1'b1;
      writeReg  <= in_rd;
      writeData <= in_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Output stage is the oldest pending write; queued entries are scanned head to
  // tail so the youngest match overwrites older ones.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0]            a,
    input logic                         out_v,
    input logic [ADDR_W-1:0]            out_rd,
    input logic [DATA_W-1:0]            out_d,
    input logic [DEPTH-1:0][EW-1:0]     ent,
    input logic [DEPTH-1:0]             v,
    input logic [PW-1:0]                rp
  );
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PW-1:0]     idx;
    hit = 1'b0;
    d   = '0;
    if (out_v && (out_rd == a)) begin
      hit = 1'b1;
      d   = out_d;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rp + PW'(k);
      if (v[idx] && (ent[idx][EW-1:DATA_W] == a)) begin
        hit = 1'b1;
        d   = ent[idx][DATA_W-1:0];
      end
    end
    if (a == ADDR_W'(ZERO_REG)) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_addr1, RegWrite, writeReg, writeData,
                                       q_ent, q_valid, q_rptr);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_addr2, RegWrite, writeReg, writeData,
                                       q_ent, q_valid, q_rptr);
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, latency, arbitration,
// burst ordering, forwarding, x0 filtering and asynchronous mid-run reset.
module tb_regfile_writeback_queue;
  import rf_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        full, empty;

  int checks = 0;
  int errors = 0;
  wb_entry_t retired[$];

  regfile_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && RegWrite) retired.push_back({writeReg, writeData});
  end

  task automatic test_reset();
    #12;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %0d want 0", writeReg); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writedata: got %h want 0", writeData); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [2:0] exp_cnt;
    retired.delete();
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", alu_ready); end
    @(posedge clk); #1 alu_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (RegWrite !== (k == LAT)) begin errors++; $display("FAIL single_regwrite_c%0d: got %b want %b", k, RegWrite, (k == LAT)); end
      if (k == LAT) begin
        checks++; if (writeReg !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_payload: got rd=%0d data=%h want 5/deadbeef", writeReg, writeData); end
      end
      if (k == 1) begin
        exp_cnt = (LAT == 2) ? 3'd1 : 3'd0;
        checks++; if (count !== exp_cnt) begin errors++; $display("FAIL single_count: got %0d want %0d", count, exp_cnt); end
      end
      if (k == 3) begin
        checks++; if (writeReg !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got rd=%0d data=%h want 5/deadbeef", writeReg, writeData); end
      end
      if (k < 3) @(posedge clk);
    end
  endtask

  task automatic test_arbitration();
    retired.delete();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    #1;
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL arb_ready: got alu=%b mem=%b want 0/1", alu_ready, mem_ready); end
    @(posedge clk); #1 mem_valid = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL arb_alu_ready_next: got %b want 1", alu_ready); end
    @(posedge clk); #1 alu_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (retired.size() != 2) begin errors++; $display("FAIL arb_retire_count: got %0d want 2", retired.size()); end
    else begin
      checks++; if (retired[0] !== {5'd3, 32'h11}) begin errors++; $display("FAIL arb_first: got rd=%0d data=%h want 3/11", retired[0].rd, retired[0].data); end
      checks++; if (retired[1] !== {5'd4, 32'h22}) begin errors++; $display("FAIL arb_second: got rd=%0d data=%h want 4/22", retired[1].rd, retired[1].data); end
    end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL arb_drained: got count=%0d empty=%b want 0/1", count, empty); end
  endtask

  task automatic test_burst();
    logic [2:0] exp_cnt;
    wb_entry_t  exp_e;
    retired.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
      #1;
      exp_cnt = (i > 0 && LAT == 2) ? 3'd1 : 3'd0;
      checks++; if (alu_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL burst_ready_%0d: got ready=%b full=%b want 1/0", i, alu_ready, full); end
      checks++; if (count !== exp_cnt) begin errors++; $display("FAIL burst_count_%0d: got %0d want %0d", i, count, exp_cnt); end
    end
    @(posedge clk); #1 alu_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (retired.size() != 6) begin errors++; $display("FAIL burst_retire_count: got %0d want 6", retired.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        exp_e.rd = 5'(10 + i); exp_e.data = 32'h100 + 32'(i);
        checks++; if (retired[i] !== exp_e) begin errors++; $display("FAIL burst_order_%0d: got rd=%0d data=%h want %0d/%h", i, retired[i].rd, retired[i].data, exp_e.rd, exp_e.data); end
      end
    end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL burst_drained: got count=%0d empty=%b want 0/1", count, empty); end
  endtask

  task automatic test_forward();
    fwd_addr1 = 5'd7; fwd_addr2 = 5'd8;
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    @(posedge clk); #1 alu_data = 32'hB;
    @(negedge clk);
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hA) begin errors++; $display("FAIL fwd_first: got hit=%b data=%h want 1/a", fwd_hit1, fwd_data1); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin errors++; $display("FAIL fwd_other_miss: got hit=%b data=%h want 0/0", fwd_hit2, fwd_data2); end
    @(posedge clk); #1 alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hB) begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h want 1/b", fwd_hit1, fwd_data1); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin errors++; $display("FAIL fwd_retired: got hit=%b data=%h want 0/0", fwd_hit1, fwd_data1); end
  endtask

  task automatic test_x0();
    retired.delete();
    fwd_addr2 = ZERO_REG;
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", alu_ready); end
    @(posedge clk); #1 alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL x0_count: got count=%0d empty=%b want 0/1", count, empty); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin errors++; $display("FAIL x0_fwd: got hit=%b data=%h want 0/0", fwd_hit2, fwd_data2); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (retired.size() != 0) begin errors++; $display("FAIL x0_no_write: got %0d writes want 0", retired.size()); end
  endtask

  task automatic test_reset_mid();
    fwd_addr1 = 5'd21;
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h55;
    @(posedge clk); #1;
    alu_rd = 5'd21; alu_data = 32'h66;
    @(posedge clk); #1 alu_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0) begin errors++; $display("FAIL midrst_output: got we=%b rd=%0d data=%h want 0/0/0", RegWrite, writeReg, writeData); end
    checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL midrst_status: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL midrst_fwd: got %b want 0", fwd_hit1); end
    retired.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (retired.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d writes want 0", retired.size()); end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    fwd_addr1 = '0; fwd_addr2 = '0;
    test_reset();
    test_single();
    test_arbitration();
    test_burst();
    test_forward();
    test_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
